vga_clut_scan: RTL
==================

# vga_clut_scan

VGA scan-out stage that sits directly around the colour lookup table. It generates 640x480 raster timing and publishes the current pixel coordinate to upstream render logic. It forwards the returned 4-bit colour index to the CLUT read port and registers the CLUT's 12-bit RGB word onto the VGA pins. Sync and blank are delayed so they stay aligned with the CLUT's one-clock registered read.

## Interface
- COLOR_BITS, 4, bits per colour channel; also the width of the index
- LINE_SIZE, 3, channels per CLUT word (R, G, B; R in the MSBs)
- CNT_BITS, 10, width of the x/y counters
- H_ACTIVE, H_FP, H_SYNC, H_BP: 640, 16, 96, 48. Horizontal segments, in pixel ticks.
- V_ACTIVE, V_FP, V_SYNC, V_BP: 480, 10, 2, 33. Vertical segments, in lines.
- clk, in, 1: single system clock. The CLUT read port is clocked by this same clk.
- rst_n, in, 1: asynchronous, active-low reset
- pix_en, in, 1: pixel tick enable. All state advances only on clk edges where pix_en=1.
- x, out, CNT_BITS: current horizontal count, 0..H_total-1
- y, out, CNT_BITS: current vertical count, 0..V_total-1
- pix_index, in, COLOR_BITS: colour index for (x,y). It is driven combinationally by upstream within the same tick.
- clut_addr, out, COLOR_BITS: CLUT read address, registered
- clut_data, in, COLOR_BITS*LINE_SIZE: CLUT registered read data
- vga_r, vga_g, vga_b, out, COLOR_BITS each: pixel colour, registered
- hsync, vsync, out, 1: sync outputs, active-low, registered
- frame_start, out, 1: one-clk pulse at the start of each frame

## Operation
- Totals: H_total = sum of the H segments (800); V_total = sum of the V segments (525).
- Counters, on a pix_en tick:
  - x increments each tick.
  - At x = H_total-1, x wraps to 0 and y increments.
  - At y = V_total-1 together with x wrap, y wraps to 0.
- Stage 0 (combinational from counters):
  - active0 = (x < H_ACTIVE) && (y < V_ACTIVE)
  - hs0 = !(H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC)
  - vs0 = !(V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC)
- Stage 1 registers, on a pix_en tick: clut_addr <= pix_index; active1, hs1, vs1 <= stage-0 values.
- Stage 2 registers, on a pix_en tick:
  - {vga_r, vga_g, vga_b} <= active1 ? clut_data : 0
  - hsync <= hs1; vsync <= vs1
- Blanking: outside the active area, RGB is forced to 0 regardless of pix_index or clut_data.
- frame_start is asserted for exactly one clk on the edge where the counters move from (H_total-1, V_total-1) to (0,0). It is 0 at all other times.
- No writes to the CLUT originate here. Palette writes use the CLUT's independent write port.

## Timing
- Reset (rst_n=0, asynchronous):
  - x=0, y=0, clut_addr=0, all RGB=0
  - hsync=1, vsync=1; active1=0, hs1=1, vs1=1
  - frame_start=0
- After reset release, the first pix_en tick moves the counters to (1,0). No frame_start is issued for the reset-entry frame.
- CLUT read latency: clut_data reflects clut_addr one clk after clut_addr changes.
- pix_en requirement: pix_en must be low for at least one clk between ticks, i.e. a 50 MHz clk with a 25 MHz tick. This guarantees clut_data is settled before stage 2 samples it.
  - Driving pix_en=1 on consecutive clks is a usage error; the output colour is then undefined.
  - Sync and counter behaviour remain correct even in that case.
- Latency: the colour, hsync and vsync for pixel (x,y) appear on the outputs two pix_en ticks after the counters first show (x,y). All three outputs stay aligned to each other.
- Holding: with pix_en=0, every register and output holds indefinitely.
- Reset mid-frame: all outputs return to their reset values immediately, with no partial sync pulse held. Scanning restarts at (0,0).

## Test plan
- Reset values: assert rst_n=0 mid-line with pix_en toggling -> x=y=0, RGB=0, hsync=vsync=1 and frame_start=0 immediately, with no clk edge needed.
- Line timing (clk 50 MHz, pix_en every 2nd clk, CLUT modelled as 1-clk ROM):
  - hsync goes low exactly 2 ticks after x reaches 656.
  - It stays low for 96 ticks.
  - The line period is 800 ticks.
- Pipeline and colour:
  - Drive pix_index = x[3:0] with CLUT entry i = {i,~i,i}.
  - Pixel x=5 on line 0 appears 2 ticks later as R=5, G=10, B=5.
  - Consecutive pixels show no skipped or duplicated indices.
- Blanking: drive pix_index=4'hF with CLUT entry 15 = 12'hFFF -> RGB=0 for all pixels with x>=640 or y>=480, and 12'hFFF inside the active area.
- Frame wrap:
  - frame_start pulses once per 420000 ticks, coincident with (x,y) returning to (0,0).
  - vsync is low for exactly 2 lines, starting 2 ticks after (0,490).
- Stall: hold pix_en=0 for 37 clks mid-line -> x, y, clut_addr, RGB and syncs are unchanged. Scanning resumes seamlessly on the next tick.

Source files
------------

// File: rtl/vga_clut_scan.sv
// vga_clut_scan
// VGA scan-out stage wrapped around a colour lookup table (CLUT).
// It generates raster timing, publishes the current pixel coordinate to the
// upstream renderer, forwards the returned colour index to the CLUT read
// port, and registers the CLUT's RGB word onto the VGA pins. Blank and sync
// are carried through a matching pipeline so they stay aligned with colour.
//
// Ports:
//   clk          system clock (also clocks the external CLUT read port)
//   rst_n        asynchronous active-low reset
//   pix_en       pixel tick enable; all state advances only when high
//   x, y         current raster coordinate
//   pix_index    colour index for (x,y), driven combinationally upstream
//   clut_addr    registered CLUT read address
//   clut_data    CLUT registered read data, R in the MSBs
//   vga_r/g/b    registered pixel colour (forced to 0 while blanking)
//   hsync/vsync  registered active-low syncs
//   frame_start  one-clk pulse when the raster wraps back to (0,0)
module vga_clut_scan #(
  parameter int COLOR_BITS = 4,
  parameter int LINE_SIZE  = 3,
  parameter int CNT_BITS   = 10,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pix_en,
  output logic [CNT_BITS-1:0]             x,
  output logic [CNT_BITS-1:0]             y,
  input  logic [COLOR_BITS-1:0]           pix_index,
  output logic [COLOR_BITS-1:0]           clut_addr,
  input  logic [COLOR_BITS*LINE_SIZE-1:0] clut_data,
  output logic [COLOR_BITS-1:0]           vga_r,
  output logic [COLOR_BITS-1:0]           vga_g,
  output logic [COLOR_BITS-1:0]           vga_b,
  output logic                            hsync,
  output logic                            vsync,
  output logic                            frame_start
);

  localparam int RGB_BITS = COLOR_BITS * LINE_SIZE;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_BITS-1:0] H_LAST     = CNT_BITS'(H_TOTAL - 1);
  localparam logic [CNT_BITS-1:0] V_LAST     = CNT_BITS'(V_TOTAL - 1);
  localparam logic [CNT_BITS-1:0] H_ACT      = CNT_BITS'(H_ACTIVE);
  localparam logic [CNT_BITS-1:0] V_ACT      = CNT_BITS'(V_ACTIVE);
  localparam logic [CNT_BITS-1:0] HS_START   = CNT_BITS'(H_ACTIVE + H_FP);
  localparam logic [CNT_BITS-1:0] HS_END     = CNT_BITS'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_BITS-1:0] VS_START   = CNT_BITS'(V_ACTIVE + V_FP);
  localparam logic [CNT_BITS-1:0] VS_END     = CNT_BITS'(V_ACTIVE + V_FP + V_SYNC);

  logic                x_last;
  logic                frame_wrap;
  logic                active0;
  logic                hs0;
  logic                vs0;
  logic                active1;
  logic                hs1;
  logic                vs1;
  logic [RGB_BITS-1:0] rgb_q;

  assign x_last     = (x == H_LAST);
  assign frame_wrap = x_last && (y == V_LAST);

  // Stage 0: decode blank and sync windows straight from the counters.
  assign active0 = (x < H_ACT) && (y < V_ACT);
  assign hs0     = !((x >= HS_START) && (x < HS_END));
  assign vs0     = !((y >= VS_START) && (y < VS_END));

  // Raster counters; y only moves when x wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (pix_en) begin
      if (x_last) begin
        x <= '0;
        if (y == V_LAST) begin
          y <= '0;
        end else begin
          y <= y + CNT_BITS'(1);
        end
      end else begin
        x <= x + CNT_BITS'(1);
      end
    end
  end

  // The pulse is generated from the pre-wrap coordinate, so it is high for
  // exactly the clk in which the counters first read (0,0). Reset entry
  // does not pass through the wrap, so no pulse is issued for that frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && frame_wrap;
    end
  end

  // Stage 1: present the index to the CLUT and carry blank/sync alongside
  // the CLUT's one-clk read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clut_addr <= '0;
      active1   <= 1'b0;
      hs1       <= 1'b1;
      vs1       <= 1'b1;
    end else if (pix_en) begin
      clut_addr <= pix_index;
      active1   <= active0;
      hs1       <= hs0;
      vs1       <= vs0;
    end
  end

  // Stage 2: the idle clk between ticks lets clut_data settle before it is
  // captured here; blanked pixels are forced to black.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_en) begin
      rgb_q <= active1 ? clut_data : '0;
      hsync <= hs1;
      vsync <= vs1;
    end
  end

  assign vga_r = rgb_q[RGB_BITS-1 -: COLOR_BITS];
  assign vga_g = rgb_q[RGB_BITS-1-COLOR_BITS -: COLOR_BITS];
  assign vga_b = rgb_q[RGB_BITS-1-2*COLOR_BITS -: COLOR_BITS];

endmodule
